// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexer scan sequencer.
package mux_scan_pkg;

    localparam int unsigned SettleCntWidth = 4;
    localparam int unsigned NumChannels    = 4;
    localparam int unsigned ChanWidth      = 2;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Control, multiplexer-select and result signals of the scan sequencer.
interface mux_scan_sequencer_if;

    logic                                 start;
    logic [mux_scan_pkg::NumChannels-1:0] mask;
    logic                                 mux_out;
    logic                                 address0;
    logic                                 address1;
    logic                                 busy;
    logic                                 done;
    logic [mux_scan_pkg::NumChannels-1:0] result;

    modport master (
        output start, mask, mux_out,
        input  address0, address1, busy, done, result
    );

    modport slave (
        input  start, mask, mux_out,
        output address0, address1, busy, done, result
    );

endinterface

// File: rtl/settle_counter.sv
// Settle timer: counts while enabled, terminal count at Cycles-1, cleared to zero on clr_i.
module settle_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned Cycles = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [SettleCntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == SettleCntWidth'(Cycles - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Walks the enabled channels of a 4:1 mux, letting each address settle before sampling mux_out.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_scan_sequencer_if.slave  bus
);

    state_e                 state_q, state_d;
    logic [NumChannels-1:0] mask_q, mask_d;
    logic [NumChannels-1:0] result_q, result_d;
    logic [ChanWidth-1:0]   addr_q, addr_d;

    logic                   cnt_clr, cnt_en, cnt_tc;
    logic [ChanWidth-1:0]   first_ch, next_ch;
    logic                   next_found;

    settle_counter #(
        .Cycles (SETTLE_CYCLES)
    ) u_settle_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    // Descending loop: the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (bus.mask[i]) begin
                first_ch = ChanWidth'(i);
            end
            if (mask_q[i] && (i > int'(addr_q))) begin
                next_ch    = ChanWidth'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        result_d = result_q;
        addr_d   = addr_q;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mask_d   = bus.mask;
                    result_d = '0;
                    if (|bus.mask) begin
                        addr_d  = first_ch;
                        state_d = StSettle;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSettle: begin
                cnt_clr = 1'b0;
                cnt_en  = !cnt_tc;
                if (cnt_tc) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                result_d[addr_q] = bus.mux_out;
                if (next_found) begin
                    addr_d  = next_ch;
                    state_d = StSettle;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            result_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.address0 = addr_q[0];
    assign bus.address1 = addr_q[1];
    assign bus.busy     = (state_q == StSettle) || (state_q == StSample);
    assign bus.done     = (state_q == StDone);
    assign bus.result   = result_q;

endmodule
